// File: rtl/synth_pkg.sv
// Shared types and constants for the note sequencer and its pattern memory.
package synth_pkg;

    localparam int STEPS      = 16;
    localparam int ADDR_W     = 4;
    localparam int DIV_W      = 32;
    localparam int CNT_W      = 32;
    localparam int MIN_PERIOD = 2;

    typedef struct packed {
        logic             rest;
        logic [DIV_W-1:0] divisor;
    } pat_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } seq_state_t;

endpackage

// File: rtl/seq_pattern_mem.sv
// Pattern storage: STEPS entries of {rest, divisor}, one write port, one async read port.
module seq_pattern_mem
    import synth_pkg::*;
#(
    parameter int STEPS  = 16,
    parameter int ADDR_W = 4,
    parameter int DIV_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIV_W:0]    wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DIV_W:0]    rd_data
);

    logic [STEPS-1:0][DIV_W:0] mem;

    // Reset leaves every slot as a rest so an unprogrammed pattern is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++)
                mem[i] <= {1'b1, {DIV_W{1'b0}}};
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: walks the pattern at a programmable tempo, driving divisor and
// note gate into the synth datapath.
module note_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS  = 16,
    parameter int ADDR_W = 4,
    parameter int DIV_W  = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              loop,
    input  logic [ADDR_W-1:0] last_step,
    input  logic [CNT_W-1:0]  step_period,
    input  logic [CNT_W-1:0]  gate_len,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIV_W:0]    wr_data,
    output logic [DIV_W-1:0]  divisor,
    output logic              trigger,
    output logic [ADDR_W-1:0] step_idx,
    output logic              step_start,
    output logic              done,
    output logic              busy
);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] eff_gate;
    logic [DIV_W:0]   rd_data;
    logic             entry_rest;
    logic [DIV_W-1:0] entry_div;
    logic             rest_q;
    logic             step_end;
    logic             at_last;

    seq_pattern_mem #(
        .STEPS  (STEPS),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (step_idx),
        .rd_data (rd_data)
    );

    assign entry_rest = rd_data[DIV_W];
    assign entry_div  = rd_data[DIV_W-1:0];

    assign eff_period = (step_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : step_period;
    assign eff_gate   = (gate_len < eff_period) ? gate_len : eff_period;
    assign step_end   = (cnt >= eff_period - CNT_W'(1));
    assign at_last    = (step_idx == last_step);

    // trigger is computed one cycle ahead from the current cnt, so the PLAY
    // cycle showing cnt=c has its gate high when c <= eff_gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rest_q     <= 1'b1;
            divisor    <= '0;
            trigger    <= 1'b0;
            step_idx   <= '0;
            step_start <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            step_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!run) begin
                        state    <= IDLE;
                        trigger  <= 1'b0;
                        busy     <= 1'b0;
                        step_idx <= '0;
                    end else begin
                        if (!entry_rest)
                            divisor <= entry_div;
                        rest_q     <= entry_rest;
                        cnt        <= CNT_W'(1);
                        step_start <= 1'b1;
                        trigger    <= !entry_rest && (eff_gate != '0);
                        state      <= PLAY;
                    end
                end
                PLAY: begin
                    if (!run) begin
                        state    <= IDLE;
                        trigger  <= 1'b0;
                        busy     <= 1'b0;
                        step_idx <= '0;
                    end else if (step_end) begin
                        trigger <= 1'b0;
                        if (at_last && !loop) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            step_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            step_idx <= at_last ? '0 : step_idx + ADDR_W'(1);
                            state    <= LOAD;
                        end
                    end else begin
                        cnt     <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
                        trigger <= !rest_q && (cnt < eff_gate);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: step-level trace model plus directed edge cases.
module tb_note_sequencer;

    typedef struct packed {
        logic [31:0] div;
        logic        trig;
        logic [3:0]  idx;
        logic        st;
        logic        dn;
        logic        bz;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        loop = 1'b0;
    logic [3:0]  last_step = '0;
    logic [31:0] step_period = '0;
    logic [31:0] gate_len = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [32:0] wr_data = '0;
    logic [31:0] divisor;
    logic        trigger;
    logic [3:0]  step_idx;
    logic        step_start;
    logic        done;
    logic        busy;
    obs_t        obs;

    int checks = 0;
    int failures = 0;

    bit          m_rest [16];
    logic [31:0] m_div  [16];
    obs_t        exp_q[$];
    logic [31:0] g_div;
    int          g_s;
    bit          g_done;

    note_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .loop(loop), .last_step(last_step),
        .step_period(step_period), .gate_len(gate_len), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .divisor(divisor), .trigger(trigger),
        .step_idx(step_idx), .step_start(step_start), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    assign obs = '{divisor, trigger, step_idx, step_start, done, busy};

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic obs_t mk(logic [31:0] d, bit t, int i, bit s, bit dn, bit b);
        obs_t o;
        o.div = d; o.trig = t; o.idx = 4'(i); o.st = s; o.dn = dn; o.bz = b;
        return o;
    endfunction

    // Expected output trace, one step at a time: a LOAD cycle followed by
    // period-1 PLAY cycles; the gate covers the first min(gate,period) PLAY cycles.
    task automatic gen_steps(int n, bit lp, int last, int per, int gate);
        int ep, eg;
        ep = (per < 2) ? 2 : per;
        eg = (gate < ep) ? gate : ep;
        for (int i = 0; i < n && !g_done; i++) begin
            exp_q.push_back(mk(g_div, 0, g_s, 0, 0, 1));
            if (!m_rest[g_s]) g_div = m_div[g_s];
            for (int j = 1; j < ep; j++)
                exp_q.push_back(mk(g_div, !m_rest[g_s] && j <= eg, g_s, j == 1, 0, 1));
            if (g_s == last && !lp) begin
                exp_q.push_back(mk(g_div, 0, 0, 0, 1, 0));
                g_done = 1;
            end else begin
                g_s = (g_s == last) ? 0 : (g_s + 1) % 16;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin m_rest[i] = 1; m_div[i] = '0; end
        g_div = '0;
    endtask

    task automatic write_entry(int a, bit r, logic [31:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = 4'(a); wr_data = {r, d};
        @(negedge clk);
        wr_en = 0;
        m_rest[a] = r; m_div[a] = d;
    endtask

    task automatic start_run(bit lp, int last, int per, int gate);
        @(negedge clk);
        loop = lp; last_step = 4'(last); step_period = 32'(per); gate_len = 32'(gate);
        exp_q.delete();
        g_s = 0; g_done = 0;
    endtask

    task automatic stop_run();
        run = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst_n = 0;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", obs); end
        rst_n = 1;
        model_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== '0) begin failures++; $display("FAIL reset_idle k=%0d got=%h exp=0", k, obs); end
        end
    endtask

    task automatic test_basic_loop();
        for (int i = 0; i < 4; i++) write_entry(i, 0, 32'(100 * (i + 1)));
        start_run(1, 3, 10, 6);
        gen_steps(5, 1, 3, 10, 6);
        run = 1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL basic k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
        end
        g_div = exp_q[exp_q.size()-1].div;
        stop_run();
    endtask

    task automatic test_rest_gate();
        int highs;
        write_entry(1, 1, 32'd999);
        start_run(1, 3, 8, 20);
        gen_steps(5, 1, 3, 8, 20);
        run = 1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL rest_gate k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
        end
        g_div = exp_q[exp_q.size()-1].div;
        stop_run();
        start_run(1, 3, 8, 0);
        gen_steps(4, 1, 3, 8, 0);
        run = 1;
        highs = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); @(negedge clk);
            if (trigger) highs++;
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL gate_zero k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
        end
        checks++;
        if (highs !== 0) begin failures++; $display("FAIL gate_zero_highs got=%0d exp=0", highs); end
        g_div = exp_q[exp_q.size()-1].div;
        stop_run();
        write_entry(1, 0, 32'd200);
    endtask

    task automatic test_single_pass();
        int pulses, at;
        start_run(0, 2, 5, 3);
        gen_steps(10, 0, 2, 5, 3);
        run = 1;
        pulses = 0; at = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin pulses++; at = k; end
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL single k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
        end
        checks++;
        if (pulses !== 1 || at !== 15) begin
            failures++; $display("FAIL single_done pulses=%0d at=%0d exp 1 at 15", pulses, at);
        end
        g_div = exp_q[exp_q.size()-1].div;
        stop_run();
    endtask

    task automatic test_stop_mid();
        int dn;
        start_run(1, 3, 10, 6);
        gen_steps(3, 1, 3, 10, 6);
        run = 1;
        for (int k = 0; k <= 23; k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL stop k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
        end
        g_div = exp_q[23].div;
        run = 0;
        dn = 0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (obs !== mk(g_div, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL stop_idle got=%h exp=%h", obs, mk(g_div, 0, 0, 0, 0, 0)); end
        repeat (5) begin @(negedge clk); if (done || busy) dn++; end
        checks++;
        if (dn !== 0) begin failures++; $display("FAIL stop_quiet got=%0d exp=0", dn); end
    endtask

    task automatic test_reset_mid();
        start_run(1, 3, 10, 6);
        run = 1;
        repeat (14) @(negedge clk);
        rst_n = 0; run = 0;
        #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL async_reset got=%h exp=0", obs); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        start_run(1, 3, 4, 4);
        gen_steps(5, 1, 3, 4, 4);
        run = 1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL reset_pattern k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
        end
        stop_run();
    endtask

    task automatic test_write_collision();
        for (int i = 0; i < 4; i++) write_entry(i, 0, 32'(1000 + i));
        start_run(1, 3, 6, 3);
        gen_steps(4, 1, 3, 6, 3);
        m_div[1] = 32'd7777;
        gen_steps(4, 1, 3, 6, 3);
        run = 1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); @(negedge clk);
            wr_en = 0;
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL collide k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
            if (k == 6) begin wr_en = 1; wr_addr = 4'd1; wr_data = {1'b0, 32'd7777}; end
        end
        g_div = exp_q[exp_q.size()-1].div;
        stop_run();
    endtask

    task automatic test_period_shrink();
        start_run(1, 3, 50, 10);
        gen_steps(1, 1, 3, 50, 10);
        while (exp_q.size() > 21) void'(exp_q.pop_back());
        gen_steps(4, 1, 3, 4, 10);
        run = 1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin failures++; $display("FAIL shrink k=%0d got=%h exp=%h", k, obs, exp_q[k]); end
            if (k == 20) step_period = 32'd4;
        end
        g_div = exp_q[exp_q.size()-1].div;
        stop_run();
    endtask

    task automatic test_random();
        int ncyc, last, per, gate, n;
        bit lp;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 6; i++)
                write_entry(i, $urandom_range(3) == 0, $urandom);
            lp = $urandom_range(1);
            last = $urandom_range(5);
            per = $urandom_range(12);
            gate = $urandom_range(14);
            ncyc = $urandom_range(70, 20);
            start_run(lp, last, per, gate);
            while (exp_q.size() < ncyc && !g_done) gen_steps(1, lp, last, per, gate);
            n = (exp_q.size() < ncyc) ? exp_q.size() : ncyc;
            run = 1;
            for (int k = 0; k < n; k++) begin
                @(posedge clk); @(negedge clk);
                checks++;
                if (obs !== exp_q[k]) begin
                    failures++;
                    $display("FAIL random it=%0d k=%0d lp=%0d last=%0d per=%0d gate=%0d got=%h exp=%h",
                             it, k, lp, last, per, gate, obs, exp_q[k]);
                end
            end
            g_div = exp_q[n-1].div;
            stop_run();
        end
    endtask

    initial begin
        test_reset();
        test_basic_loop();
        test_rest_gate();
        test_single_pass();
        test_stop_mid();
        test_write_collision();
        test_period_shrink();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Step sequencer that plays a programmable pattern of notes into the synth datapath.
- Each step drives the oscillator divisor and the envelope trigger level.
- Sits between the wishbone register block and synth_top. The register block writes pattern entries and run/timing configuration; this block replaces direct software toggling of divisor/trigger with cycle-accurate tempo timing.

Parameters:
- STEPS, 16, pattern depth (power of two).
- ADDR_W, 4, log2(STEPS).
- DIV_W, 32, oscillator divisor width.
- CNT_W, 32, width of step_period / gate_len / internal tick counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = play pattern, 0 = stop
- loop  input  1  1 = wrap after last step; 0 = single pass then stop
- last_step  input  ADDR_W  index of final step in pattern
- step_period  input  CNT_W  clocks per step (values <2 treated as 2)
- gate_len  input  CNT_W  clocks trigger is high within a step
- wr_en  input  1  pattern write strobe
- wr_addr  input  ADDR_W  pattern write address
- wr_data  input  DIV_W+1  {rest, divisor}
- divisor  output  DIV_W  to synth_top divisor
- trigger  output  1  to synth_top trigger (note gate)
- step_idx  output  ADDR_W  step currently playing
- step_start  output  1  one-cycle pulse on first PLAY cycle of each step
- done  output  1  one-cycle pulse when a single pass completes
- busy  output  1  high in LOAD/PLAY

Behaviour:
Reset (async, rst_n=0):
- All outputs 0; state IDLE; tick counter 0.
- Every pattern entry reset to {rest=1, divisor=0}.

Registered outputs:
- Every output is registered and takes its value on the edge entering the state that defines it.

States IDLE, LOAD, PLAY:
- IDLE
  - trigger=0, busy=0, step_idx=0, divisor holds its last value.
  - run=1 -> LOAD.
- LOAD (1 cycle)
  - Read pattern[step_idx].
  - If rest=0: divisor <= entry divisor. If rest=1: divisor holds.
  - cnt <= 1; trigger forced 0, which guarantees one low cycle between consecutive notes so the envelope retriggers.
  - -> PLAY.
- PLAY
  - step_start=1 on the first PLAY cycle only.
  - trigger=1 while (rest=0 && cnt < eff_gate), where eff_gate = min(gate_len, step_period), with step_period as effective value.
  - cnt increments each cycle.
  - When cnt >= step_period-1 (step ends):
    - If step_idx == last_step and loop=0: pulse done, -> IDLE.
    - Otherwise: step_idx <= (step_idx == last_step) ? 0 : step_idx+1, -> LOAD.
  - Step length is exactly step_period clocks (1 LOAD + step_period-1 PLAY).

run=0:
- From LOAD or PLAY, the next edge goes to IDLE: trigger=0, step_idx=0, no done pulse.
- run=0 takes priority over step end in the same cycle.

Configuration and writes:
- step_period, gate_len, last_step are sampled live every cycle.
  - Shrinking step_period below cnt ends the step on the next cycle (>= compare).
  - last_step lowered below step_idx: wrap occurs when step_idx reaches ADDR_W all-ones and rolls to 0 (natural overflow); no stall.
- gate_len=0: trigger never asserts (equivalent to rest).
- Pattern writes are allowed at any time.
  - A write to the entry being loaded in the same cycle: LOAD sees the old data; the new data plays on the next visit.
  - A write to the currently playing step does not affect divisor until that step is reloaded.
- Counter saturates at all-ones; it never wraps mid-step.

Decomposition:
- Package synth_pkg:
  - Pattern entry struct {rest, divisor}.
  - State enum {IDLE, LOAD, PLAY}.
  - Constants STEPS, ADDR_W, DIV_W, CNT_W.
  - MIN_PERIOD=2.
- One natural sub-module: seq_pattern_mem.
  - STEPS x (DIV_W+1) flop array, async-reset to rest entries.
  - One write port; one combinational read port.
- FSM, tick counter and output registers live in note_sequencer.

Test Plan:
1. Reset then idle: rst_n=0 pulse with run=0 -> all outputs 0, no activity for 100 cycles.
2. Basic loop: write steps 0..3 divisors 100,200,300,400; last_step=3, step_period=10, gate_len=6, loop=1, run=1 -> divisor sequence 100,200,300,400,100…; each step 10 cycles; trigger high exactly 6 cycles starting with step_start; 1 low cycle at each LOAD.
3. Rest and gate edges: step 1 rest=1, gate_len=20 with step_period=8 -> step 1 holds divisor 100 with trigger 0; other steps trigger high 7 cycles; gate_len=0 -> trigger never high.
4. Single pass: loop=0, last_step=2, step_period=5 -> done pulses once, 15 cycles after run rises (+1 pipeline), busy drops the same cycle, step_idx=0.
5. Stop/reset mid-step: drop run in PLAY cycle 3 of step 2 -> next cycle IDLE, trigger 0, no done. Separately assert rst_n=0 mid-PLAY -> outputs clear asynchronously and pattern returns to rest entries.
6. Write collision: wr_en to step_idx+1 in the same cycle that step enters LOAD -> old divisor plays; new value appears on the next loop pass. step_period reduced from 50 to 4 at cnt=20 -> step ends the next cycle.
